// File: rtl/pixel_pkg.sv
// pixel_pkg: shared constants for the CCD pixel packing path
package pixel_pkg;
  localparam int CCD_PIX_W = 12;
  localparam logic MODE_TRUNC = 1'b0;
  localparam logic MODE_THRESH = 1'b1;
endpackage

// File: rtl/pix_quant.sv
// pix_quant: reduces a 12-bit CCD pixel to PIX_W bits by truncation or threshold
module pix_quant
  import pixel_pkg::*;
#(
  parameter int PIX_W = 1
) (
  input  logic [CCD_PIX_W-1:0] iDATA,
  input  logic                 iMODE,
  input  logic [CCD_PIX_W-1:0] iTHRESH,
  output logic [PIX_W-1:0]     oQ
);
  always_comb oQ = (iMODE == MODE_THRESH) ? {PIX_W{iDATA >= iTHRESH}} : iDATA[CCD_PIX_W-1 -: PIX_W];
endmodule

// File: rtl/pixel_packer.sv
// pixel_packer: packs quantised pixels into WORD_W-bit strobed words with end-of-frame flush
module pixel_packer
  import pixel_pkg::*;
#(
  parameter int PIX_W  = 1,
  parameter int WORD_W = 16,
  parameter int CNT_W  = 20
) (
  input  logic                 iCLK,
  input  logic                 iRST_N,
  input  logic [CCD_PIX_W-1:0] iDATA,
  input  logic                 iDVAL,
  input  logic                 iFVAL,
  input  logic                 iMODE,
  input  logic [CCD_PIX_W-1:0] iTHRESH,
  output logic [WORD_W-1:0]    oDATA,
  output logic                 oDVAL,
  output logic                 oEOF,
  output logic [CNT_W-1:0]     oWORD_CNT
);
  localparam int PPW = WORD_W / PIX_W;
  localparam int SLOT_W = PPW > 1 ? $clog2(PPW) : 1;
  localparam logic [SLOT_W-1:0] LAST = SLOT_W'(PPW - 1);
  logic fval_d, mode_l, mode, rise, fall, acc, done, flush;
  logic [CCD_PIX_W-1:0] thresh_l, thresh;
  logic [SLOT_W-1:0] slot_cnt, slot;
  logic [WORD_W-1:0] shreg, sh, packed_w;
  logic [CNT_W-1:0] cnt, cnt_inc;
  logic [PIX_W-1:0] q;
  // a pixel arriving on the frame-start cycle already uses the newly latched mode
  pix_quant #(.PIX_W(PIX_W)) u_quant (
    .iDATA(iDATA),
    .iMODE(mode),
    .iTHRESH(thresh),
    .oQ(q)
  );
  always_comb begin
    rise = iFVAL & ~fval_d;
    fall = ~iFVAL & fval_d;
    acc = iFVAL & iDVAL;
    mode = rise ? iMODE : mode_l;
    thresh = rise ? iTHRESH : thresh_l;
    slot = rise ? '0 : slot_cnt;
    sh = rise ? '0 : shreg;
    packed_w = sh | (WORD_W'(q) << (slot * PIX_W));
    done = acc & (slot == LAST);
    flush = fall & (slot_cnt != '0);
    cnt = rise ? '0 : oWORD_CNT;
    cnt_inc = (&cnt) ? cnt : cnt + CNT_W'(1);
  end
  always_ff @(posedge iCLK) begin
    if (!iRST_N) begin
      fval_d <= 1'b0;
      mode_l <= MODE_TRUNC;
      thresh_l <= '0;
      slot_cnt <= '0;
      shreg <= '0;
      oDATA <= '0;
      oDVAL <= 1'b0;
      oEOF <= 1'b0;
      oWORD_CNT <= '0;
    end else begin
      fval_d <= iFVAL;
      mode_l <= mode;
      thresh_l <= thresh;
      oDVAL <= done | flush;
      oEOF <= fall;
      oWORD_CNT <= (done | flush) ? cnt_inc : cnt;
      if (done | flush) oDATA <= done ? packed_w : shreg;
      slot_cnt <= (done | flush) ? '0 : acc ? slot + SLOT_W'(1) : slot;
      shreg <= (done | flush) ? '0 : acc ? packed_w : sh;
    end
  end
endmodule

// File: tb/tb_pixel_packer.sv
// tb_pixel_packer: directed checks of pixel_packer in 1-bit and 4-bit packing configurations
module tb_pixel_packer;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n, fval, dval, mode;
  logic [11:0] data, thresh;
  logic [15:0] d1, d4;
  logic v1, e1, v4, e4;
  logic [19:0] c1;
  logic [1:0] c4;
  int checks = 0, errors = 0, n1 = 0, n4 = 0, b1, b4;
  pixel_packer #(.PIX_W(1), .WORD_W(16), .CNT_W(20)) u1 (
    .iCLK(clk), .iRST_N(rst_n), .iDATA(data), .iDVAL(dval), .iFVAL(fval),
    .iMODE(mode), .iTHRESH(thresh), .oDATA(d1), .oDVAL(v1), .oEOF(e1), .oWORD_CNT(c1)
  );
  pixel_packer #(.PIX_W(4), .WORD_W(16), .CNT_W(2)) u4 (
    .iCLK(clk), .iRST_N(rst_n), .iDATA(data), .iDVAL(dval), .iFVAL(fval),
    .iMODE(mode), .iTHRESH(thresh), .oDATA(d4), .oDVAL(v4), .oEOF(e4), .oWORD_CNT(c4)
  );
  always @(posedge clk) begin
    if (v1) n1++;
    if (v4) n4++;
  end
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic pix(input logic [11:0] d);
    data = d;
    dval = 1'b1;
    fval = 1'b1;
    step();
    dval = 1'b0;
  endtask
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask
  initial begin
    rst_n = 1'b0; fval = 1'b0; dval = 1'b0; mode = 1'b1; thresh = 12'd100; data = '0;
    step(); step();
    check("rst_data", 32'(d1), 32'h0);
    check("rst_dval", 32'(v1), 32'h0);
    check("rst_eof", 32'(e1), 32'h0);
    check("rst_cnt", 32'(c1), 32'h0);
    rst_n = 1'b1;
    step();
    b1 = n1;
    for (int i = 0; i < 16; i++) pix(i % 2 == 0 ? 12'd200 : 12'd50);
    check("t1_dval", 32'(v1), 32'h1);
    check("t1_data", 32'(d1), 32'h5555);
    check("t1_cnt", 32'(c1), 32'h1);
    step();
    check("t1_dval_low", 32'(v1), 32'h0);
    check("t1_hold", 32'(d1), 32'h5555);
    fval = 1'b0;
    step();
    check("t1_eof", 32'(e1), 32'h1);
    check("t1_eof_nodval", 32'(v1), 32'h0);
    check("t1_pulses", 32'(n1 - b1), 32'h1);
    step();
    check("t1_eof_low", 32'(e1), 32'h0);
    mode = 1'b0;
    pix(12'h1FF); pix(12'h2FF); pix(12'h3FF); pix(12'h4FF);
    check("t2_dval4", 32'(v4), 32'h1);
    check("t2_data4", 32'(d4), 32'h4321);
    fval = 1'b0;
    step();
    check("t2_eof4", 32'(e4), 32'h1);
    check("t2_nodval4", 32'(v4), 32'h0);
    check("t2_flush1", 32'({v1, e1, d1}), 32'h30000);
    step();
    mode = 1'b1;
    for (int i = 0; i < 5; i++) pix(12'd4095);
    fval = 1'b0;
    step();
    check("t3_flush1", 32'({v1, e1, d1}), 32'h3001F);
    check("t3_cnt1", 32'(c1), 32'h1);
    check("t3_flush4", 32'({v4, e4, d4}), 32'h3000F);
    check("t3_cnt4", 32'(c4), 32'h2);
    step();
    check("t3_pulse_end", 32'({v1, e1}), 32'h0);
    dval = 1'b1; data = 12'd4095;
    step(); step(); step();
    dval = 1'b0;
    check("t4_outframe", 32'(v1), 32'h0);
    b1 = n1;
    for (int i = 0; i < 16; i++) begin
      pix(i % 2 == 0 ? 12'd200 : 12'd50);
      if (i != 15) begin step(); step(); end
    end
    check("t4_data", 32'({v1, d1}), 32'h15555);
    check("t4_pulses", 32'(n1 - b1), 32'h0);
    fval = 1'b0; dval = 1'b1;
    step();
    dval = 1'b0;
    check("t4_eof", 32'({v1, e1}), 32'h1);
    check("t4_one_word", 32'(n1 - b1), 32'h1);
    step();
    b4 = n4;
    for (int i = 0; i < 16; i++) begin
      if (i == 8) mode = 1'b0;
      pix(12'd200);
    end
    check("t5_keep_mode", 32'({v1, d1}), 32'h1FFFF);
    check("t5_sat4", 32'(c4), 32'h3);
    check("t5_words4", 32'(n4 - b4 + (v4 ? 1 : 0)), 32'h4);
    fval = 1'b0;
    step(); step();
    for (int i = 0; i < 16; i++) pix(12'd200);
    check("t5_new_mode", 32'({v1, d1}), 32'h10000);
    fval = 1'b0;
    step(); step();
    mode = 1'b1;
    for (int i = 0; i < 7; i++) pix(12'd200);
    b1 = n1;
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    check("t5_rst_nodval", 32'({v1, d1}), 32'h0);
    for (int i = 0; i < 16; i++) begin
      if (i == 15) check("t5_no_early", 32'(n1 - b1 + (v1 ? 1 : 0)), 32'h0);
      pix(i % 2 == 0 ? 12'd50 : 12'd200);
    end
    check("t5_clean", 32'({v1, d1}), 32'h1AAAA);
    check("t5_clean_cnt", 32'(c1), 32'h1);
    fval = 1'b0;
    step(); step();
    b1 = n1;
    for (int i = 0; i < 32; i++) begin
      pix(i % 2 == 0 ? 12'd200 : 12'd50);
      if (i == 15) check("t6_w1", 32'({v1, d1, c1[3:0]}), 32'h155551);
    end
    check("t6_w2", 32'({v1, d1, c1[3:0]}), 32'h155552);
    fval = 1'b0;
    step();
    check("t6_eof", 32'({v1, e1}), 32'h1);
    check("t6_cnt", 32'(c1), 32'h2);
    check("t6_words", 32'(n1 - b1), 32'h2);
    step();
    fval = 1'b1;
    step();
    check("t6_cnt_clear", 32'(c1), 32'h0);
    fval = 1'b0;
    step();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/pixel_packer.md
# pixel_packer

Parametrised packer between the CCD pixel pipeline (RAW2RGB output) and an SDRAM write FIFO port. Each accepted 12-bit pixel is quantised to PIX_W bits, either by truncation or by threshold. Quantised pixels are packed into WORD_W-bit words, first pixel in the least significant slot. The block emits each word as a one-cycle strobe, flushes a zero-padded partial word at end of frame, and counts words per frame. It replaces the fixed 1-bit/16-word shift packer and its divided write clock with a single-clock, strobe-based design.

## Interface
- PIX_W, 1: bits per packed pixel; one of 1, 2, 4, 8.
- WORD_W, 16: output word width; must be a multiple of PIX_W.
- PPW, WORD_W/PIX_W: pixels per word. Derived localparam, not overridable.
- CNT_W, 20: width of the per-frame word counter.

Ports:
- iCLK  in  1  sole clock (CCD pixel clock domain).
- iRST_N  in  1  reset; synchronous, active-low.
- iDATA  in  12  pixel value.
- iDVAL  in  1  pixel valid.
- iFVAL  in  1  frame valid.
- iMODE  in  1  quantisation mode. 0 = truncate (PIX_W MSBs of iDATA); 1 = threshold.
- iTHRESH  in  12  threshold value; used in threshold mode.
- oDATA  out  WORD_W  packed word.
- oDVAL  out  1  one-cycle strobe; oDATA is valid while it is high.
- oEOF  out  1  one-cycle end-of-frame pulse.
- oWORD_CNT  out  CNT_W  number of words emitted in the current or last frame.

## Operation
- Accept rule: a pixel is accepted on a rising edge of iCLK when iDVAL=1 and iFVAL=1. iDVAL is ignored while iFVAL=0.
- Quantisation, truncate mode: q = iDATA[11:12-PIX_W].
- Quantisation, threshold mode: q = all ones if iDATA >= iTHRESH (unsigned compare), otherwise all zeros.
- Mode and threshold are latched when a frame starts. A change of iMODE or iTHRESH mid-frame has no effect until the next frame.
- Frame start: a rising edge of iFVAL, detected against the previous registered iFVAL. On frame start:
  - slot counter clears to 0;
  - shift register clears to 0;
  - oWORD_CNT clears to 0;
  - the mode/threshold latch loads.
- Packing: an accepted pixel writes q into slot number slot_cnt, then slot_cnt increments.
- Word completion: when slot_cnt reaches PPW-1 and a pixel is accepted:
  - the full word is registered onto oDATA and oDVAL=1 on the next cycle;
  - slot_cnt wraps to 0;
  - oWORD_CNT increments.
- Flush: on a falling edge of iFVAL with slot_cnt>0:
  - the partial word is emitted with its unfilled upper slots set to 0;
  - oDVAL=1 and oEOF=1 on the same cycle;
  - oWORD_CNT increments; slot_cnt clears.
- Falling edge of iFVAL with slot_cnt=0: oEOF pulses alone, with no oDVAL.
- A word completion and a flush never coincide, because completion requires iFVAL=1 and flush requires iFVAL=0.
- oWORD_CNT saturates at all ones and never wraps.
- Reset mid-word: the partial word is discarded and nothing is emitted.

## Timing
- Latency: 1 cycle from the accepting edge of the completing pixel to oDVAL high.
- Flush latency: 1 cycle from the first cycle with iFVAL=0 to oDVAL/oEOF high.
- oDVAL and oEOF are high for exactly 1 cycle per event.
- oDATA holds its value between strobes.
- Throughput: one pixel per cycle with no stalls. There is no backpressure; the downstream FIFO must absorb 1 word per PPW cycles.
- Reset values: oDATA=0, oDVAL=0, oEOF=0, oWORD_CNT=0, slot_cnt=0, registered iFVAL=0.
  - Consequence: an iFVAL already high when reset releases is treated as a frame start on the first cycle.

## Structure
- Shared package pixel_pkg holds:
  - mode constants: MODE_TRUNC=1'b0, MODE_THRESH=1'b1;
  - the 12-bit pixel width constant CCD_PIX_W=12.
- Sub-module pix_quant: a combinational quantiser with ports iDATA, iMODE, iTHRESH, oQ[PIX_W-1:0].
- Slot counter, shift register, edge detector and word counter live in pixel_packer.

## Test plan
- PIX_W=1, WORD_W=16, threshold mode, iTHRESH=100. Stimulus: 16 consecutive pixels alternating 200, 50. Response: oDATA=16'h5555, one oDVAL pulse 1 cycle after the 16th pixel, oWORD_CNT=1.
- PIX_W=4, WORD_W=16, truncate mode. Stimulus: pixels 12'h1FF, 12'h2FF, 12'h3FF, 12'h4FF. Response: oDATA=16'h4321.
- PIX_W=1, threshold mode, all pixels 4095. Stimulus: 5 pixels, then iFVAL falls. Response: oDATA=16'h001F, with oDVAL and oEOF high together 1 cycle after the fall.
- Stimulus: iDVAL gaps (valid every 3rd cycle) plus iDVAL=1 while iFVAL=0. Response: only in-frame pixels are packed; word content is identical to the gap-free run.
- Stimulus: iMODE toggled mid-frame. Response: no effect until the next iFVAL rise. Stimulus: iRST_N=0 for one cycle after 7 pixels. Response: no word emitted; the next 16 pixels form a clean word.
- Stimulus: exactly 32 pixels, then iFVAL falls. Response: two words, then oEOF without oDVAL; oWORD_CNT=2, and it clears on the next frame start.
